// File: rtl/icache_if.sv
// Lookup and byte-refill bus between the instruction cache, its two fetch
// ports and the memory controller.
interface icache_if;
  logic        rdy;
  logic        en_rx;
  logic        en_ry;
  logic [31:0] pcx;
  logic [31:0] pcy;
  logic        flush;
  logic        hitx;
  logic        hity;
  logic [31:0] instx;
  logic [31:0] insty;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_byte;

  modport master (
    output rdy, en_rx, en_ry, pcx, pcy, flush, mem_valid, mem_byte,
    input  hitx, hity, instx, insty, mem_req, mem_addr
  );

  modport slave (
    input  rdy, en_rx, en_ry, pcx, pcy, flush, mem_valid, mem_byte,
    output hitx, hity, instx, insty, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with two combinational
// lookup ports and a byte-serial refill engine.
module icache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input logic     clk,
  input logic     rst,
  icache_if.slave bus
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                  state;
  logic [1:0]              cnt;
  logic                    discard;
  logic [31:0]             fill_addr;
  logic [31:0]             buf_q;
  logic                    mem_req_q;
  logic [31:0]             mem_addr_q;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic [INDEX_BITS-1:0]   idx_x, idx_y, idx_f;
  logic [TAG_W-1:0]        tag_x, tag_y;
  logic                    hit_x, hit_y, miss_x, miss_y, wr_en;
  logic [31:0]             start_addr;
  logic                    unused_low_bits;

  assign idx_x = bus.pcx[INDEX_BITS+1:2];
  assign idx_y = bus.pcy[INDEX_BITS+1:2];
  assign tag_x = bus.pcx[31:INDEX_BITS+2];
  assign tag_y = bus.pcy[31:INDEX_BITS+2];
  assign idx_f = fill_addr[INDEX_BITS+1:2];

  // Zero-latency lookup; both ports may read the same line
  assign hit_x = bus.en_rx & valid[idx_x] & (tag_mem[idx_x] == tag_x);
  assign hit_y = bus.en_ry & valid[idx_y] & (tag_mem[idx_y] == tag_y);

  assign bus.hitx  = hit_x;
  assign bus.hity  = hit_y;
  assign bus.instx = hit_x ? data_mem[idx_x] : 32'h0;
  assign bus.insty = hit_y ? data_mem[idx_y] : 32'h0;

  assign miss_x     = bus.en_rx & ~hit_x;
  assign miss_y     = bus.en_ry & ~hit_y;
  assign start_addr = miss_x ? {bus.pcx[31:2], 2'b00} : {bus.pcy[31:2], 2'b00};

  // A flush in the write cycle, or any earlier in the fill, suppresses the write
  assign wr_en = (state == WRITE) & bus.rdy & ~discard & ~bus.flush;

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  assign unused_low_bits = ^{bus.pcx[1:0], bus.pcy[1:0]};

  // Line storage carries no reset; the valid bits alone qualify it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[idx_f] <= buf_q;
      tag_mem[idx_f]  <= fill_addr[31:INDEX_BITS+2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      discard    <= 1'b0;
      fill_addr  <= 32'h0;
      buf_q      <= 32'h0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      valid      <= '0;
    end else if (bus.rdy) begin
      case (state)
        IDLE: begin
          if (miss_x || miss_y) begin
            fill_addr  <= start_addr;
            mem_addr_q <= start_addr;
            mem_req_q  <= 1'b1;
            cnt        <= 2'd0;
            discard    <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (bus.flush) discard <= 1'b1;
          if (bus.mem_valid) begin
            // Byte k lands in bits [31-8k -: 8], i.e. lsb at 8*(3-k)
            buf_q[{~cnt, 3'b000} +: 8] <= bus.mem_byte;
            cnt        <= cnt + 2'd1;
            mem_addr_q <= mem_addr_q + 32'd1;
            if (cnt == 2'd3) begin
              mem_req_q <= 1'b0;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          if (wr_en) valid[idx_f] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (bus.flush) valid <= '0;
    end
  end

endmodule
